// File: rtl/sccb_config_sequencer_if.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer_if
// Bus between the configuration sequencer (master) and the SCCB/I2C byte
// master (slave).
//
// Signals:
//   bus_req   master -> slave  transaction request
//   bus_rd    master -> slave  1 = read, 0 = write
//   bus_reg   master -> slave  register address
//   bus_wdata master -> slave  write data
//   bus_rdata slave -> master  read data, valid with bus_ack
//   bus_ack   slave -> master  one-cycle completion pulse
//   bus_nack  slave -> master  no-acknowledge, meaningful only with bus_ack
//
// Handshake: the master raises bus_req and holds bus_req, bus_rd, bus_reg and
// bus_wdata constant until the slave pulses bus_ack for exactly one cycle.
// bus_req falls the cycle after bus_ack, and at least one idle cycle
// separates two requests. A request may be withdrawn without an ack only
// when the master is reset.
// -----------------------------------------------------------------------------
interface sccb_config_sequencer_if;
    logic       bus_req;
    logic       bus_rd;
    logic [7:0] bus_reg;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       bus_nack;

    modport master (
        output bus_req, bus_rd, bus_reg, bus_wdata,
        input  bus_rdata, bus_ack, bus_nack
    );

    modport slave (
        input  bus_req, bus_rd, bus_reg, bus_wdata,
        output bus_rdata, bus_ack, bus_nack
    );
endinterface

// File: rtl/sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer
// Walks a window of a register-table LUT ({reg_addr, reg_data} entries) and
// writes each entry through the SCCB byte master. Supports readback verify,
// bounded retry, in-table delay entries (reg 0xFF), a hold-off after a
// soft-reset write (reg 0x12, data bit7 set) and a power-up wait.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         one-cycle start pulse, ignored while busy
//   i_tbl_base      first LUT index (sampled on accepted start)
//   i_tbl_len       number of entries (sampled on accepted start), 0 = done
//   o_lut_index     LUT address
//   i_lut_data      LUT entry, valid one cycle after o_lut_index changes
//   bus             SCCB master bus (master modport)
//   o_busy          sequence in progress
//   o_done          sticky success, cleared on start or rst
//   o_error         sticky failure, cleared on start or rst
//   o_err_index     LUT index of the failing entry
//   o_progress      entries completed in the current run
//   o_state         FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module sccb_config_sequencer #(
    parameter int IDX_W             = 8,
    parameter int POWERUP_CYCLES    = 1000,
    parameter int RESET_WAIT_CYCLES = 50000,
    parameter int DELAY_UNIT        = 1000,
    parameter int MAX_RETRY         = 3,
    parameter int VERIFY_EN         = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [IDX_W-1:0]           i_tbl_base,
    input  logic [IDX_W-1:0]           i_tbl_len,
    output logic [IDX_W-1:0]           o_lut_index,
    input  logic [15:0]                i_lut_data,
    sccb_config_sequencer_if.master    bus,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [IDX_W-1:0]           o_err_index,
    output logic [IDX_W-1:0]           o_progress,
    output logic [3:0]                 o_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PWR_WAIT = 4'd1,
        S_FETCH    = 4'd2,
        S_LUT_WAIT = 4'd3,
        S_DELAY    = 4'd4,
        S_WR       = 4'd5,
        S_WR_GAP   = 4'd6,
        S_RD       = 4'd7,
        S_RETRY    = 4'd8,
        S_RST_WAIT = 4'd9,
        S_NEXT     = 4'd10,
        S_DONE     = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDX_W-1:0] r_base;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] r_progress;
    logic [IDX_W-1:0] r_err_index;
    logic [7:0]       r_reg;
    logic [7:0]       r_data;
    logic [7:0]       r_retry;
    logic [31:0]      r_cnt;
    logic             r_done;
    logic             r_error;

    logic [IDX_W-1:0] w_cur_index;
    logic [IDX_W-1:0] w_progress_inc;
    logic             w_cnt_last;
    logic             w_can_retry;
    logic             w_soft_rst;
    logic             w_is_delay;
    logic             w_rd_ok;
    logic [31:0]      w_delay_load;

    // Index arithmetic wraps modulo 2^IDX_W by construction.
    assign w_cur_index    = r_base + r_progress;
    assign w_progress_inc = r_progress + 1'b1;

    // Wait states load r_cnt with N and leave when it reaches 1, so a
    // state lasts exactly N cycles (minimum one).
    assign w_cnt_last   = (r_cnt <= 32'd1);
    assign w_can_retry  = (r_retry < 8'(MAX_RETRY));
    assign w_soft_rst   = (r_reg == 8'h12) && r_data[7];
    assign w_is_delay   = (i_lut_data[15:8] == 8'hFF);
    assign w_rd_ok      = !bus.bus_nack && (bus.bus_rdata == r_data);
    assign w_delay_load = 32'(i_lut_data[7:0]) * 32'(DELAY_UNIT);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_tbl_len == '0) ? S_DONE : S_PWR_WAIT;
                end
            end
            S_PWR_WAIT: begin
                if (w_cnt_last) w_state_next = S_FETCH;
            end
            S_FETCH: w_state_next = S_LUT_WAIT;
            S_LUT_WAIT: begin
                // Decode straight off the LUT output; a zero-length delay
                // entry skips the DELAY state entirely.
                if (w_is_delay) begin
                    w_state_next = (i_lut_data[7:0] == 8'h00) ? S_NEXT : S_DELAY;
                end else begin
                    w_state_next = S_WR;
                end
            end
            S_DELAY: begin
                if (w_cnt_last) w_state_next = S_NEXT;
            end
            S_WR: begin
                if (bus.bus_ack) begin
                    if (bus.bus_nack) begin
                        w_state_next = w_can_retry ? S_RETRY : S_ERROR;
                    end else if (w_soft_rst) begin
                        w_state_next = S_RST_WAIT;
                    end else if (VERIFY_EN != 0) begin
                        w_state_next = S_WR_GAP;
                    end else begin
                        w_state_next = S_NEXT;
                    end
                end
            end
            // One idle bus cycle between the write and its readback.
            S_WR_GAP: w_state_next = S_RD;
            S_RD: begin
                if (bus.bus_ack) begin
                    if (w_rd_ok) begin
                        w_state_next = S_NEXT;
                    end else begin
                        w_state_next = w_can_retry ? S_RETRY : S_ERROR;
                    end
                end
            end
            // Also provides the idle bus cycle before the repeated write.
            S_RETRY: w_state_next = S_WR;
            S_RST_WAIT: begin
                if (w_cnt_last) w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = (w_progress_inc == r_len) ? S_DONE : S_FETCH;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERROR: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_len       <= '0;
            r_progress  <= '0;
            r_err_index <= '0;
            r_reg       <= 8'h00;
            r_data      <= 8'h00;
            r_retry     <= 8'h00;
            r_cnt       <= 32'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base     <= i_tbl_base;
                        r_len      <= i_tbl_len;
                        r_progress <= '0;
                        r_retry    <= 8'h00;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cnt      <= 32'(POWERUP_CYCLES);
                    end
                end
                S_PWR_WAIT, S_DELAY, S_RST_WAIT: begin
                    if (!w_cnt_last) r_cnt <= r_cnt - 32'd1;
                end
                S_LUT_WAIT: begin
                    r_reg  <= i_lut_data[15:8];
                    r_data <= i_lut_data[7:0];
                    r_cnt  <= w_delay_load;
                end
                S_WR: begin
                    if (bus.bus_ack && !bus.bus_nack && w_soft_rst) begin
                        r_cnt <= 32'(RESET_WAIT_CYCLES);
                    end
                end
                S_RETRY: r_retry <= r_retry + 8'd1;
                S_NEXT: begin
                    r_progress <= w_progress_inc;
                    r_retry    <= 8'h00;
                end
                default: ;
            endcase

            // Flags are set on entry so they are visible in the DONE/ERROR
            // cycle itself; this also overrides the clear done on start.
            if (w_state_next == S_DONE) begin
                r_done <= 1'b1;
            end
            if (w_state_next == S_ERROR) begin
                r_error     <= 1'b1;
                r_err_index <= w_cur_index;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        o_busy      = 1'b1;
        bus.bus_req = 1'b0;
        bus.bus_rd  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: o_busy = 1'b0;
            S_WR: bus.bus_req = 1'b1;
            S_RD: begin
                bus.bus_req = 1'b1;
                bus.bus_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    // Only updated in LUT_WAIT, so they are stable for the whole handshake.
    assign bus.bus_reg   = r_reg;
    assign bus.bus_wdata = r_data;

    assign o_lut_index = w_cur_index;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_index = r_err_index;
    assign o_progress  = r_progress;
    assign o_state     = r_state;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_config_sequencer
// Two sequencer instances share clock and reset: dut_a without readback
// verify, dut_b with it. The bench plays the SCCB slave, serving requests
// in a directed order and checking each one against an expected queue.
// -----------------------------------------------------------------------------
module tb_sccb_config_sequencer;

    localparam int PWR  = 20;
    localparam int RSTW = 60;
    localparam int DU   = 10;
    localparam int MR   = 3;
    localparam int TMO  = 2000;

    // ---------------------------------------------------- clock and reset
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------- DUT A
    logic        a_start;
    logic [7:0]  a_base, a_len, a_lut_index, a_err_index, a_progress;
    logic [15:0] a_lut_data;
    logic        a_busy, a_done, a_error;
    logic [3:0]  a_state;
    sccb_config_sequencer_if bus_a ();

    sccb_config_sequencer #(
        .IDX_W(8), .POWERUP_CYCLES(PWR), .RESET_WAIT_CYCLES(RSTW),
        .DELAY_UNIT(DU), .MAX_RETRY(MR), .VERIFY_EN(0)
    ) dut_a (
        .clk(clk), .rst(rst), .i_start(a_start), .i_tbl_base(a_base),
        .i_tbl_len(a_len), .o_lut_index(a_lut_index), .i_lut_data(a_lut_data),
        .bus(bus_a), .o_busy(a_busy), .o_done(a_done), .o_error(a_error),
        .o_err_index(a_err_index), .o_progress(a_progress), .o_state(a_state)
    );

    // ------------------------------------------------------------- DUT B
    logic        b_start;
    logic [7:0]  b_base, b_len, b_lut_index, b_err_index, b_progress;
    logic [15:0] b_lut_data;
    logic        b_busy, b_done, b_error;
    logic [3:0]  b_state;
    sccb_config_sequencer_if bus_b ();

    sccb_config_sequencer #(
        .IDX_W(8), .POWERUP_CYCLES(PWR), .RESET_WAIT_CYCLES(RSTW),
        .DELAY_UNIT(DU), .MAX_RETRY(MR), .VERIFY_EN(1)
    ) dut_b (
        .clk(clk), .rst(rst), .i_start(b_start), .i_tbl_base(b_base),
        .i_tbl_len(b_len), .o_lut_index(b_lut_index), .i_lut_data(b_lut_data),
        .bus(bus_b), .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
        .o_err_index(b_err_index), .o_progress(b_progress), .o_state(b_state)
    );

    // LUT models: synchronous read, data valid one cycle after the index.
    logic [15:0] lut_a [256];
    logic [15:0] lut_b [256];

    always @(posedge clk) begin
        a_lut_data <= lut_a[a_lut_index];
        b_lut_data <= lut_b[b_lut_index];
    end

    // --------------------------------------------------------- scoreboard
    // Entry: {rd, reg, wdata}; reads carry wdata = 0.
    logic [16:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({1'b0, r, d});
    endtask

    task automatic push_rd(input logic [7:0] r);
        exp_q.push_back({1'b1, r, 8'h00});
    endtask

    function automatic logic get_req(input int sel);
        return (sel == 0) ? bus_a.bus_req : bus_b.bus_req;
    endfunction

    // ------------------------------------------------------ driver tasks
    task automatic do_start(input int sel, input logic [7:0] base, input logic [7:0] len);
        @(negedge clk);
        if (sel == 0) begin
            a_base = base; a_len = len; a_start = 1'b1;
        end else begin
            b_base = base; b_len = len; b_start = 1'b1;
        end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Waits for the next request, checks it against the expected queue and
    // acknowledges it. waited = negedges until the request was seen.
    task automatic serve(input int sel, input logic nk, input logic [7:0] rdata, output int waited);
        logic        seen;
        logic [16:0] exp_t;
        logic [16:0] obs_t;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            waited++;
            if (get_req(sel)) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        exp_t = exp_q.pop_front();
        if (sel == 0) obs_t = {bus_a.bus_rd, bus_a.bus_reg, bus_a.bus_wdata};
        else          obs_t = {bus_b.bus_rd, bus_b.bus_reg, bus_b.bus_wdata};
        if (obs_t[16]) obs_t[7:0] = 8'h00;
        check("bus_txn", 32'(obs_t), 32'(exp_t));
        if (sel == 0) begin
            bus_a.bus_ack = 1'b1; bus_a.bus_nack = nk; bus_a.bus_rdata = rdata;
        end else begin
            bus_b.bus_ack = 1'b1; bus_b.bus_nack = nk; bus_b.bus_rdata = rdata;
        end
        @(negedge clk);
        bus_a.bus_ack = 1'b0; bus_a.bus_nack = 1'b0;
        bus_b.bus_ack = 1'b0; bus_b.bus_nack = 1'b0;
        check("req_drop_after_ack", 32'(get_req(sel)), 32'd0);
    endtask

    task automatic wait_done(input int sel);
        logic fin;
        fin = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if ((sel == 0) ? (a_done || a_error) : (b_done || b_error)) begin
                fin = 1'b1;
                break;
            end
        end
        check("run_finished", 32'(fin), 32'd1);
    endtask

    // Counts requests seen over a window in which none are expected.
    task automatic quiet(input int sel, input int cycles, input string tag);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (get_req(sel)) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        int w;
        logic seen;
        rst = 1'b1;
        a_start = 1'b0; a_base = 8'h00; a_len = 8'h00;
        b_start = 1'b0; b_base = 8'h00; b_len = 8'h00;
        bus_a.bus_ack = 1'b0; bus_a.bus_nack = 1'b0; bus_a.bus_rdata = 8'h00;
        bus_b.bus_ack = 1'b0; bus_b.bus_nack = 1'b0; bus_b.bus_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 16'h0000;
            lut_b[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_state",     32'(a_state),     32'd0);
        check("rst_busy",      32'(a_busy),      32'd0);
        check("rst_done",      32'(a_done),      32'd0);
        check("rst_error",     32'(a_error),     32'd0);
        check("rst_progress",  32'(a_progress),  32'd0);
        check("rst_lut_index", 32'(a_lut_index), 32'd0);
        check("rst_err_index", 32'(a_err_index), 32'd0);
        check("rst_req",       32'(bus_a.bus_req), 32'd0);
        check("rst_b_busy",    32'(b_busy),      32'd0);

        // 1) Three plain writes, immediate ack, no verify
        lut_a[2] = 16'h1214; lut_a[3] = 16'h40d0; lut_a[4] = 16'h8c02;
        push_wr(8'h12, 8'h14); push_wr(8'h40, 8'hd0); push_wr(8'h8c, 8'h02);
        do_start(0, 8'd2, 8'd3);
        check("t1_busy", 32'(a_busy), 32'd1);
        serve(0, 1'b0, 8'h00, w);
        serve(0, 1'b0, 8'h00, w);
        check("t1_lat_entry1", 32'(w), 32'd3);
        serve(0, 1'b0, 8'h00, w);
        check("t1_lat_entry2", 32'(w), 32'd3);
        wait_done(0);
        check("t1_done",     32'(a_done),     32'd1);
        check("t1_error",    32'(a_error),    32'd0);
        check("t1_progress", 32'(a_progress), 32'd3);
        check("t1_busy_end", 32'(a_busy),     32'd0);

        // 2) Soft reset write on the verifying instance: no readback of it,
        //    hold-off before the next write, then normal verify
        lut_b[10] = 16'h1280; lut_b[11] = 16'h1214;
        push_wr(8'h12, 8'h80); push_wr(8'h12, 8'h14); push_rd(8'h12);
        do_start(1, 8'd10, 8'd2);
        serve(1, 1'b0, 8'h00, w);
        serve(1, 1'b0, 8'h00, w);
        check("t2_rst_holdoff_min", 32'(w >= RSTW), 32'd1);
        check("t2_rst_holdoff_max", 32'(w <= RSTW + 10), 32'd1);
        serve(1, 1'b0, 8'h14, w);
        check("t2_verify_gap", 32'(w), 32'd1);
        wait_done(1);
        check("t2_done",     32'(b_done),     32'd1);
        check("t2_progress", 32'(b_progress), 32'd2);

        // 3) Delay entry 0xFF05 -> 50 silent cycles before the next write
        lut_a[20] = 16'h40d0; lut_a[21] = 16'hFF05; lut_a[22] = 16'h8c02;
        push_wr(8'h40, 8'hd0); push_wr(8'h8c, 8'h02);
        do_start(0, 8'd20, 8'd3);
        serve(0, 1'b0, 8'h00, w);
        serve(0, 1'b0, 8'h00, w);
        check("t3_delay_min", 32'(w >= 5 * DU), 32'd1);
        check("t3_delay_max", 32'(w <= 5 * DU + 10), 32'd1);
        wait_done(0);
        check("t3_done",     32'(a_done),     32'd1);
        check("t3_progress", 32'(a_progress), 32'd3);

        // 4) Three nacks then success on entry 1; a start while busy is ignored
        lut_a[30] = 16'h3a04; lut_a[31] = 16'h1101; lut_a[32] = 16'h3b05;
        push_wr(8'h3a, 8'h04);
        for (int i = 0; i < MR + 1; i++) push_wr(8'h11, 8'h01);
        push_wr(8'h3b, 8'h05);
        do_start(0, 8'd30, 8'd3);
        check("t4_done_cleared", 32'(a_done), 32'd0);
        do_start(0, 8'd99, 8'd7);
        serve(0, 1'b0, 8'h00, w);
        for (int i = 0; i < MR; i++) serve(0, 1'b1, 8'h00, w);
        serve(0, 1'b0, 8'h00, w);
        serve(0, 1'b0, 8'h00, w);
        wait_done(0);
        check("t4_done",     32'(a_done),     32'd1);
        check("t4_error",    32'(a_error),    32'd0);
        check("t4_progress", 32'(a_progress), 32'd3);

        // 5) Nack on every attempt of entry 1 -> error at base + 1
        push_wr(8'h3a, 8'h04);
        for (int i = 0; i < MR + 1; i++) push_wr(8'h11, 8'h01);
        do_start(0, 8'd30, 8'd3);
        serve(0, 1'b0, 8'h00, w);
        for (int i = 0; i < MR + 1; i++) serve(0, 1'b1, 8'h00, w);
        wait_done(0);
        check("t5_error",     32'(a_error),     32'd1);
        check("t5_done",      32'(a_done),      32'd0);
        check("t5_err_index", 32'(a_err_index), 32'd31);
        check("t5_busy",      32'(a_busy),      32'd0);
        quiet(0, 30, "t5_no_req_after_error");

        // 6) Readback mismatch forces one rewrite of 0x40d0
        lut_b[40] = 16'h40d0; lut_b[41] = 16'h8c02;
        push_wr(8'h40, 8'hd0); push_rd(8'h40);
        push_wr(8'h40, 8'hd0); push_rd(8'h40);
        push_wr(8'h8c, 8'h02); push_rd(8'h8c);
        do_start(1, 8'd40, 8'd2);
        serve(1, 1'b0, 8'h00, w);
        serve(1, 1'b0, 8'h00, w);
        serve(1, 1'b0, 8'h00, w);
        serve(1, 1'b0, 8'hd0, w);
        serve(1, 1'b0, 8'h00, w);
        serve(1, 1'b0, 8'h02, w);
        wait_done(1);
        check("t6_done",     32'(b_done),     32'd1);
        check("t6_error",    32'(b_error),    32'd0);
        check("t6_progress", 32'(b_progress), 32'd2);
        check("t6_exp_q_drained", 32'(exp_q.size()), 32'd0);

        // 7) Reset while a request is pending, then a zero-length run
        lut_a[50] = 16'h1101;
        do_start(0, 8'd50, 8'd1);
        check("t7_error_cleared", 32'(a_error), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (get_req(0)) begin
                seen = 1'b1;
                break;
            end
        end
        check("t7_req_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_req_withdrawn", 32'(bus_a.bus_req), 32'd0);
        check("t7_busy_after_rst", 32'(a_busy), 32'd0);
        check("t7_state_idle", 32'(a_state), 32'd0);
        do_start(0, 8'd0, 8'd0);
        check("t7_len0_done", 32'(a_done), 32'd1);
        check("t7_len0_busy", 32'(a_busy), 32'd0);
        check("t7_len0_progress", 32'(a_progress), 32'd0);
        quiet(0, 10, "t7_len0_no_req");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Parametrised successor to the fixed OV7670 register-table LUT.
- Walks a LUT of 16-bit {reg_addr, reg_data} entries and issues each entry as a write to the SCCB/I2C byte master.
- Adds optional readback verify, bounded retry, in-table delay entries, soft-reset hold-off, a power-up wait, and selectable table base/length, so one sequencer serves several camera modes.
- Sits between the register-table LUT and the SCCB master; runs once per start request.

Parameters:
- IDX_W, 8, width of lut_index and of the length/base counters.
- POWERUP_CYCLES, 1000, idle cycles after start before the first fetch.
- RESET_WAIT_CYCLES, 50000, hold-off after a soft-reset write (reg 0x12, data bit7 = 1).
- DELAY_UNIT, 1000, clk cycles per count of a delay entry.
- MAX_RETRY, 3, retries per entry after the first attempt (0 = no retry).
- VERIFY_EN, 1, read back and compare each written register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sequence; ignored while busy.
- tbl_base  in  IDX_W  first LUT index; sampled on accepted start.
- tbl_len  in  IDX_W  number of entries; sampled on accepted start; 0 = go straight to done.
- lut_index  out  IDX_W  LUT address.
- lut_data  in  16  LUT entry, [15:8] reg, [7:0] data; valid 1 cycle after lut_index changes.
- bus_req  out  1  transaction request; held until bus_ack.
- bus_rd  out  1  1 = read, 0 = write; stable while bus_req = 1.
- bus_reg  out  8  register address.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data; valid with bus_ack.
- bus_ack  in  1  one-cycle completion pulse.
- bus_nack  in  1  no-acknowledge flag; meaningful only when bus_ack = 1.
- busy  out  1  sequence in progress.
- done  out  1  sticky success; cleared on start or rst.
- error  out  1  sticky failure; cleared on start or rst.
- err_index  out  IDX_W  index of the failing entry.
- progress  out  IDX_W  entries completed in the current run.

Behaviour:
- Reset values: all outputs 0, lut_index = 0, FSM = IDLE.
- IDLE: on start, latch base/len, clear done/error/progress, set busy.
  - len = 0 -> DONE next cycle.
  - Otherwise -> PWR_WAIT for POWERUP_CYCLES.
- FETCH: drive lut_index = base + progress. Next cycle (LUT_WAIT) latch lut_data into reg/data registers.
- Decode:
  - reg = 0xFF: delay entry -> DELAY for data*DELAY_UNIT cycles; data = 0 means zero wait. No bus access.
  - Otherwise -> WR.
- WR: bus_req = 1, bus_rd = 0. Hold bus_req, bus_reg and bus_wdata constant until bus_ack.
  - bus_req drops the cycle after bus_ack.
  - A new request needs at least 1 idle cycle between requests.
- On ack with nack = 1: retry the same entry (back to WR) if retry_cnt < MAX_RETRY, else ERROR.
- On clean write ack:
  - reg = 0x12 and data[7] = 1 -> RST_WAIT for RESET_WAIT_CYCLES; verify is skipped.
  - VERIFY_EN = 1 -> RD (bus_rd = 1, same handshake).
  - Otherwise -> NEXT.
- RD ack:
  - nack, or bus_rdata != data -> counts as a retry and restarts at WR.
  - Match -> NEXT.
- retry_cnt is per entry and resets to 0 at NEXT.
- NEXT: progress += 1.
  - progress == len -> DONE.
  - Otherwise -> FETCH.
- lut_index arithmetic is modulo 2^IDX_W; base + len overflowing wraps silently and is legal.
- DONE: done = 1, busy = 0 -> IDLE.
- ERROR: error = 1, err_index = failing index, busy = 0 -> IDLE.
- start while busy: ignored, no effect.
- start in the same cycle as the transition to IDLE: accepted on the next start pulse only.
- rst mid-transaction: FSM returns to IDLE and bus_req drops on the next edge. The SCCB master sees the request withdrawn and must tolerate it.
- Latency, clean entry, VERIFY_EN = 0: 2 cycles (FETCH, LUT_WAIT) + write handshake + 1 (NEXT).

Test Plan:
- Table of 3 entries {0x1214, 0x40d0, 0x8c02}, base = 2, len = 3, immediate ack, VERIFY_EN = 0 -> three writes in order with matching reg/wdata; done = 1, progress = 3, error = 0.
- Entry 0x1280 followed by 0x1214 -> no readback on reg 0x12; bus_req stays low for ≥ RESET_WAIT_CYCLES between the two writes.
- Delay entry 0xFF05, DELAY_UNIT = 10 -> no bus activity for 50 cycles, then the next entry is written.
- nack on the first 3 write attempts of entry 1, MAX_RETRY = 3 -> 4th attempt succeeds, done = 1. With nack on all 4 attempts -> error = 1, err_index = base + 1, busy = 0.
- VERIFY_EN = 1, bus_rdata = 0x00 on the first read of 0x40d0, then 0xd0 -> exactly 2 writes and 2 reads for that entry; done = 1.
- rst asserted while bus_req = 1 -> next cycle bus_req = 0, busy = 0. A new start with tbl_len = 0 -> done after 1 cycle with no bus_req.
